log2_pipe_param: RTL and testbench

// - Parametrised, fully pipelined base-2 logarithm: unsigned IN_W-bit input -> fixed-point {integer, fraction} output.
// - Successor to the fixed 24->8 log block: generic widths, valid/ready flow control, zero-input flag, optional interpolation.
// - Sits in the datapath between sample capture and dB/AGC scaling; accepts one sample per cycle when not stalled.

---
 rtl/log2_pipe_param.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_log2_pipe_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_pipe_param.sv
// log2_pipe_param
// Fully pipelined unsigned base-2 logarithm with valid/ready flow control.
// dout = {p, frac}, where p is the position of the leading one and frac is
// the fractional part of log2 taken from a table indexed by the mantissa bits
// below that leading one. A zero operand raises dout_zero and forces dout to 0.
// The table is computed at elaboration time from the parameters.
// Optional build macro: LOG2_INTERP_EN
//   undefined : 3-stage pipe (encode, normalise, table lookup)
//   defined   : adds INTERP_W residual bits and a linear interpolation stage
//               over a table with 2 guard bits (4-stage pipe).
// The whole pipe advances together; a blocked full output slot holds every stage.

module log2_pipe_param #(
  parameter int IN_W   = 24,
  parameter int INT_W  = 5,
  parameter int FRAC_W = 4,
  parameter int ADDR_W = 5
`ifdef LOG2_INTERP_EN
  ,
  parameter int INTERP_W = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [INT_W+FRAC_W-1:0] dout,
  output logic                    dout_zero,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam int LUT_N = 1 << ADDR_W;
  localparam int PREC  = 30;
`ifdef LOG2_INTERP_EN
  localparam int SUB_W = ADDR_W + INTERP_W;
  localparam int LI_W  = FRAC_W + 3;
  localparam int ACC_W = LI_W + INTERP_W + 1;
`else
  localparam int SUB_W = ADDR_W;
`endif
  localparam int EXT_W = IN_W + SUB_W;
  localparam logic [FRAC_W-1:0] FRAC_MAX = {FRAC_W{1'b1}};

  // floor(log2(1 + k/2**ADDR_W) * 2**nbits), computed by repeated squaring
  // of a Q1.PREC mantissa; every result bit comes from one squaring step.
  function automatic logic [31:0] log2_fx(input int k, input int nbits);
    logic [63:0] z;
    logic [31:0] acc;
    z   = (64'd1 << PREC) + (64'(k) << (PREC - ADDR_W));
    acc = 32'd0;
    if (z >= (64'd2 << PREC)) begin
      acc = 32'd1;
      z   = z >> 1;
    end
    for (int b = 0; b < nbits; b++) begin
      z   = (z * z) >> PREC;
      acc = acc << 1;
      if (z >= (64'd2 << PREC)) begin
        acc = acc | 32'd1;
        z   = z >> 1;
      end
    end
    return acc;
  endfunction

`ifdef LOG2_INTERP_EN
  // Table entry with two guard bits below the output LSB, rounded half up.
  function automatic logic [LI_W-1:0] luti_entry(input int k);
    logic [31:0] t;
    t = (log2_fx(k, FRAC_W + 3) + 32'd1) >> 1;
    return t[LI_W-1:0];
  endfunction
`else
  // Table entry at output precision, rounded half up and saturated.
  function automatic logic [FRAC_W-1:0] frac_entry(input int k);
    logic [31:0] t;
    t = (log2_fx(k, FRAC_W + 1) + 32'd1) >> 1;
    if (t > 32'(FRAC_MAX)) begin
      return FRAC_MAX;
    end else begin
      return t[FRAC_W-1:0];
    end
  endfunction
`endif

  // ---------------------------------------------------------------- flow
  logic adv_s;
  logic out_v_q, out_v_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic dout_zero_q, dout_zero_d;

  // Whole pipe advances unless the output slot is full and not accepted.
  always_comb begin
    adv_s     = ~out_v_q | dout_ready;
    din_ready = adv_s;
  end

  // ---------------------------------------------------------------- S1
  logic              s1_v_q, s1_v_d;
  logic [IN_W-1:0]   s1_din_q, s1_din_d;
  logic [INT_W-1:0]  s1_p_q, s1_p_d;
  logic              s1_zero_q, s1_zero_d;
  logic [INT_W-1:0]  enc_p_s;

  // Priority encoder: index of the most significant set bit of din.
  always_comb begin
    enc_p_s = {INT_W{1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      if (din[i]) begin
        enc_p_s = INT_W'(i);
      end else begin
        enc_p_s = enc_p_s;
      end
    end
  end

  // S1 next state: capture operand, leading-one index and zero flag.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_din_d  = s1_din_q;
    s1_p_d    = s1_p_q;
    s1_zero_d = s1_zero_q;
    if (adv_s) begin
      s1_v_d    = din_valid;
      s1_din_d  = din;
      s1_p_d    = enc_p_s;
      s1_zero_d = (din == {IN_W{1'b0}});
    end else begin
      s1_v_d    = s1_v_q;
    end
  end

  // S1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_din_q  <= {IN_W{1'b0}};
      s1_p_q    <= {INT_W{1'b0}};
      s1_zero_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_din_q  <= s1_din_d;
      s1_p_q    <= s1_p_d;
      s1_zero_q <= s1_zero_d;
    end
  end

  // ---------------------------------------------------------------- S2
  logic              s2_v_q, s2_v_d;
  logic [INT_W-1:0]  s2_p_q, s2_p_d;
  logic [SUB_W-1:0]  s2_sub_q, s2_sub_d;
  logic              s2_zero_q, s2_zero_d;
  logic [SUB_W-1:0]  norm_s;

  // Normaliser: the SUB_W bits directly below the leading one, zero-filled
  // on the right when the leading one sits near the LSB.
  always_comb begin
    norm_s = SUB_W'({s1_din_q, {SUB_W{1'b0}}} >> s1_p_q);
  end

  // S2 next state.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_p_d    = s2_p_q;
    s2_sub_d  = s2_sub_q;
    s2_zero_d = s2_zero_q;
    if (adv_s) begin
      s2_v_d    = s1_v_q;
      s2_p_d    = s1_p_q;
      s2_sub_d  = norm_s;
      s2_zero_d = s1_zero_q;
    end else begin
      s2_v_d    = s2_v_q;
    end
  end

  // S2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_p_q    <= {INT_W{1'b0}};
      s2_sub_q  <= {SUB_W{1'b0}};
      s2_zero_q <= 1'b0;
    end else begin
      s2_v_q    <= s2_v_d;
      s2_p_q    <= s2_p_d;
      s2_sub_q  <= s2_sub_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  // Signals presented to the output register by the last compute stage.
  logic              pre_v_s;
  logic              pre_zero_s;
  logic [OUT_W-1:0]  pre_dout_s;

`ifdef LOG2_INTERP_EN
  // ---------------------------------------------------------------- S3 (table fetch)
  logic [LI_W-1:0]     luti_s [LUT_N+1];
  logic [ADDR_W-1:0]   m_s;
  logic [INTERP_W-1:0] r_s;
  logic [ADDR_W:0]     idx_lo_s, idx_hi_s;

  for (genvar k = 0; k <= LUT_N; k++) begin : g_luti
    localparam logic [LI_W-1:0] LV = luti_entry(k);
    assign luti_s[k] = LV;
  end

  logic                s3_v_q, s3_v_d;
  logic [INT_W-1:0]    s3_p_q, s3_p_d;
  logic                s3_zero_q, s3_zero_d;
  logic [LI_W-1:0]     s3_lo_q, s3_lo_d, s3_hi_q, s3_hi_d;
  logic [INTERP_W-1:0] s3_r_q, s3_r_d;

  // Split mantissa / residual and fetch the two bracketing table entries.
  always_comb begin
    m_s      = s2_sub_q[SUB_W-1 -: ADDR_W];
    r_s      = s2_sub_q[INTERP_W-1:0];
    idx_lo_s = {1'b0, m_s};
    idx_hi_s = {1'b0, m_s} + {{ADDR_W{1'b0}}, 1'b1};
  end

  // S3 next state.
  always_comb begin
    s3_v_d    = s3_v_q;
    s3_p_d    = s3_p_q;
    s3_zero_d = s3_zero_q;
    s3_lo_d   = s3_lo_q;
    s3_hi_d   = s3_hi_q;
    s3_r_d    = s3_r_q;
    if (adv_s) begin
      s3_v_d    = s2_v_q;
      s3_p_d    = s2_p_q;
      s3_zero_d = s2_zero_q;
      s3_lo_d   = luti_s[idx_lo_s];
      s3_hi_d   = luti_s[idx_hi_s];
      s3_r_d    = r_s;
    end else begin
      s3_v_d    = s3_v_q;
    end
  end

  // S3 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v_q    <= 1'b0;
      s3_p_q    <= {INT_W{1'b0}};
      s3_zero_q <= 1'b0;
      s3_lo_q   <= {LI_W{1'b0}};
      s3_hi_q   <= {LI_W{1'b0}};
      s3_r_q    <= {INTERP_W{1'b0}};
    end else begin
      s3_v_q    <= s3_v_d;
      s3_p_q    <= s3_p_d;
      s3_zero_q <= s3_zero_d;
      s3_lo_q   <= s3_lo_d;
      s3_hi_q   <= s3_hi_d;
      s3_r_q    <= s3_r_d;
    end
  end

  // ---------------------------------------------------------------- S4 (interpolate)
  logic [ACC_W-1:0]  acc_s, rnd_s;
  logic [FRAC_W-1:0] ifrac_s;

  // Linear interpolation between table entries, rounded half up to the
  // output precision and saturated below 1.0.
  always_comb begin
    acc_s = (ACC_W'(s3_lo_q) << INTERP_W) + ACC_W'(s3_hi_q - s3_lo_q) * ACC_W'(s3_r_q);
    rnd_s = (acc_s + (ACC_W'(1) << (INTERP_W + 1))) >> (INTERP_W + 2);
    if (rnd_s > ACC_W'(FRAC_MAX)) begin
      ifrac_s = FRAC_MAX;
    end else begin
      ifrac_s = rnd_s[FRAC_W-1:0];
    end
    pre_v_s    = s3_v_q;
    pre_zero_s = s3_zero_q;
    pre_dout_s = {s3_p_q, ifrac_s};
  end
`else
  // ---------------------------------------------------------------- S3 (table lookup)
  logic [FRAC_W-1:0] lut_s [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [FRAC_W-1:0] LV = frac_entry(k);
    assign lut_s[k] = LV;
  end

  // Fraction straight from the table.
  always_comb begin
    pre_v_s    = s2_v_q;
    pre_zero_s = s2_zero_q;
    pre_dout_s = {s2_p_q, lut_s[s2_sub_q]};
  end
`endif

  // ---------------------------------------------------------------- output
  // Output next state: zero operands report dout = 0 with the flag raised.
  always_comb begin
    out_v_d     = out_v_q;
    dout_d      = dout_q;
    dout_zero_d = dout_zero_q;
    if (adv_s) begin
      out_v_d     = pre_v_s;
      dout_zero_d = pre_zero_s;
      if (pre_zero_s) begin
        dout_d = {OUT_W{1'b0}};
      end else begin
        dout_d = pre_dout_s;
      end
    end else begin
      out_v_d     = out_v_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      dout_q      <= {OUT_W{1'b0}};
      dout_zero_q <= 1'b0;
    end else begin
      out_v_q     <= out_v_d;
      dout_q      <= dout_d;
      dout_zero_q <= dout_zero_d;
    end
  end

  assign dout       = dout_q;
  assign dout_zero  = dout_zero_q;
  assign dout_valid = out_v_q;

endmodule

// File: tb/tb_log2_pipe_param.sv
// Self-checking bench for log2_pipe_param (default parameters).
// A floating-point reference computes each expected output when the input
// handshake completes; a queue keeps expectations in order and one monitor
// compares every output handshake, the din_ready rule and the latency.

module tb_log2_pipe_param;

  localparam int IN_W   = 24;
  localparam int INT_W  = 5;
  localparam int FRAC_W = 4;
  localparam int ADDR_W = 5;
  localparam int OUT_W  = INT_W + FRAC_W;
`ifdef LOG2_INTERP_EN
  localparam int SUB_W  = ADDR_W + 4;
  localparam int LAT    = 4;
`else
  localparam int SUB_W  = ADDR_W;
  localparam int LAT    = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  din;
  logic             din_valid;
  logic             din_ready;
  logic [OUT_W-1:0] dout;
  logic             dout_zero;
  logic             dout_valid;
  logic             dout_ready;

  log2_pipe_param dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_zero  (dout_zero),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_stall = -1;
  int out_cnt = 0;
  bit prev_rst = 1'b0;

  logic [OUT_W-1:0] exp_d [$];
  bit               exp_z [$];
  int               exp_c [$];
  logic [OUT_W-1:0] mon_e;
  bit               mon_z;
  int               mon_c;
  logic [IN_W-1:0]  stall_vals [8];

  // Reference: log2(v) ~= p + frac/2**FRAC_W with frac rounded half up.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] v);
    int unsigned     vv;
    int              p;
    longint unsigned m;
    real             y;
    int              f;
    if (v == '0) return '0;
    vv = v;
    p  = $clog2(vv + 1) - 1;
    m  = ((longint'(vv) << SUB_W) >> p) % (64'd1 << SUB_W);
    y  = $ln(1.0 + real'(m) / real'(64'd1 << SUB_W)) / $ln(2.0) * real'(1 << FRAC_W);
    f  = $rtoi($floor(y + 0.5));
    if (f > (1 << FRAC_W) - 1) f = (1 << FRAC_W) - 1;
    return OUT_W'((p << FRAC_W) + f);
  endfunction

  function automatic logic [IN_W-1:0] rand_din();
    logic [IN_W-1:0] ones;
    ones = '1;
    case ($urandom_range(0, 7))
      0: return '0;
      1: return IN_W'(1);
      2: return IN_W'(1) << $urandom_range(0, IN_W - 1);
      3: return ones >> $urandom_range(0, IN_W - 1);
      default: return IN_W'($urandom) >> $urandom_range(0, IN_W - 1);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: sample mid-cycle, check output handshakes, then record inputs.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      exp_d.delete();
      exp_z.delete();
      exp_c.delete();
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("reset_dout_valid", int'(dout_valid), 0);
        chk("reset_dout", int'(dout), 0);
        chk("reset_dout_zero", int'(dout_zero), 0);
      end
      prev_rst = 1'b0;
      chk("din_ready", int'(din_ready), int'(!dout_valid || dout_ready));
      if (dout_valid && !dout_ready) last_stall = cyc;
      if (dout_valid && dout_ready) begin
        out_cnt++;
        if (exp_d.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_out: dout_valid=1 with nothing pending, dout=0x%0h (cycle %0d)", dout, cyc);
        end else begin
          mon_e = exp_d.pop_front();
          mon_z = exp_z.pop_front();
          mon_c = exp_c.pop_front();
          chk("dout_zero", int'(dout_zero), int'(mon_z));
`ifdef LOG2_INTERP_EN
          n_vec++;
          if (dout[OUT_W-1:FRAC_W] !== mon_e[OUT_W-1:FRAC_W] ||
              int'(dout[FRAC_W-1:0]) - int'(mon_e[FRAC_W-1:0]) > 1 ||
              int'(mon_e[FRAC_W-1:0]) - int'(dout[FRAC_W-1:0]) > 1) begin
            n_fail++;
            $display("FAIL dout: got 0x%0h expected 0x%0h +-1 LSB (cycle %0d)", dout, mon_e, cyc);
          end
`else
          chk("dout", int'(dout), int'(mon_e));
`endif
          if (mon_c > last_stall) chk("latency", cyc - mon_c, LAT);
        end
      end
      if (din_valid && din_ready) begin
        exp_d.push_back(model(din));
        exp_z.push_back(din == '0);
        exp_c.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] v);
    int k;
    k = 0;
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
    #1;
    while (!din_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("send_accepted", int'(din_ready), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  initial begin
    int idx;
    int base;
    int k;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    stall_vals = '{24'h000001, 24'h000005, 24'h000100, 24'h0ABCDE,
                   24'h000000, 24'hFFFFFF, 24'h001234, 24'h000003};

    // Hand-computed anchors for the reference itself.
    chk("model_one", int'(model(24'h000001)), 'h000);
    chk("model_zero", int'(model(24'h000000)), 'h000);
    chk("model_msb", int'(model(24'h800000)), 'h170);
    chk("model_full", int'(model(24'hFFFFFF)), 'h17F);
    chk("model_three", int'(model(24'h000003)), 'h019);
    chk("model_two", int'(model(24'h000002)), 'h010);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed: one then zero back-to-back, then boundary values.
    send(24'h000001);
    send(24'h000000);
    idle(6);
    send(24'h800000);
    send(24'hFFFFFF);
    send(24'h000003);
    idle(6);

    // Eight samples with the sink blocked for cycles 4..7.
    base = out_cnt;
    idx = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      dout_ready = !(t >= 4 && t <= 7);
      if (idx < 8) begin
        din = stall_vals[idx];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      #1;
      if (din_valid && din_ready) idx++;
    end
    chk("stall_sent", idx, 8);
    chk("stall_outputs", out_cnt - base, 8);
    chk("stall_pending", exp_d.size(), 0);

    // Reset with three samples in flight while the output is blocked.
    dout_ready = 1'b1;
    send(24'h00F00D);
    send(24'h123456);
    send(24'h000007);
    @(negedge clk);
    din_valid = 1'b0;
    dout_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    base = out_cnt;
    idle(10);
    chk("reset_no_stale", out_cnt - base, 0);

    // Randomised traffic with alternating backpressure phases and rare resets.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      if (((t / 200) % 2) == 1) dout_ready = ($urandom_range(0, 3) == 0);
      else dout_ready = ($urandom_range(0, 3) != 0);
      din = rand_din();
    end

    // Drain.
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    k = 0;
    while (exp_d.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #3;
    chk("drain_empty", exp_d.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
